// File: rtl/tca_pkg.sv
// Shared definitions for the TCA request-to-systolic-array sequencer.
package tca_pkg;

  localparam int TCA_ADDR_W   = 20;
  localparam int TCA_DATA_W   = 128;
  localparam int TCA_MAX_ROWS = 16;
  localparam int TCA_OFIFO_D  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_COMPUTE,
    S_DRAIN,
    S_RESP
  } tca_seq_state_t;

  typedef logic [TCA_DATA_W-1:0] tca_row_t;

  // A tile must carry at least one row and fit in the array.
  function automatic logic tca_rows_bad(input logic [15:0] rows, input int max_rows);
    return (rows == 16'd0) || (int'(rows) > max_rows);
  endfunction

endpackage

// File: rtl/tca_out_fifo.sv
// Output row FIFO between the systolic array and the psum write port.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module tca_out_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/tca_sa_sequencer.sv
// Runs one tile: load ifmap rows from scratchpad into the SA, start it, write SA rows
// back to the psum region, then issue one complete/error response pulse.
module tca_sa_sequencer
  import tca_pkg::*;
#(
  parameter int ADDR_W   = TCA_ADDR_W,
  parameter int DATA_W   = TCA_DATA_W,
  parameter int MAX_ROWS = TCA_MAX_ROWS,
  parameter int OFIFO_D  = TCA_OFIFO_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base_addr,
  input  logic [ADDR_W-1:0] req_psum_addr,
  input  logic [15:0]       req_rows,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rvalid,
  input  logic [DATA_W-1:0] rd_rdata,
  output logic              sa_valid,
  output logic              sa_load_ifmap,
  output logic              sa_start,
  output logic [DATA_W-1:0] sa_din,
  input  logic              sa_rvalid,
  input  logic              sa_done,
  input  logic [DATA_W-1:0] sa_dout,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              res_valid,
  output logic              res_complete,
  output logic              res_error
);

  tca_seq_state_t    r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_psum;
  logic [15:0]       r_rows;
  logic [15:0]       r_issued;
  logic [15:0]       r_recvd;
  logic [15:0]       r_wcnt;
  logic              r_err;
  logic              r_res_valid;
  logic              r_res_complete;
  logic              r_res_error;

  logic              w_in_load;
  logic              w_rd_want;
  logic              w_rd_fire;
  logic              w_load_beat;
  logic              w_out_phase;
  logic              w_push;
  logic              w_pop;
  logic              w_overflow;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  assign w_in_load   = (r_state == S_LOAD);
  assign w_rd_want   = w_in_load && (r_issued < r_rows);
  assign w_rd_fire   = w_rd_want & rd_ready;
  assign w_load_beat = w_in_load & rd_rvalid;
  assign w_out_phase = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
  assign w_push      = w_out_phase & sa_rvalid;
  assign w_pop       = wr_valid & wr_ready;
  assign w_overflow  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_psum         <= '0;
      r_rows         <= '0;
      r_issued       <= '0;
      r_recvd        <= '0;
      r_wcnt         <= '0;
      r_err          <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_complete <= 1'b0;
      r_res_error    <= 1'b0;
    end else begin
      r_res_valid    <= 1'b0;
      r_res_complete <= 1'b0;
      r_res_error    <= 1'b0;
      if (w_pop)      r_wcnt <= r_wcnt + 16'd1;
      if (w_overflow) r_err  <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_base   <= req_base_addr;
            r_psum   <= req_psum_addr;
            r_rows   <= req_rows;
            r_issued <= '0;
            r_recvd  <= '0;
            r_wcnt   <= '0;
            if (tca_rows_bad(req_rows, MAX_ROWS)) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_rd_fire) r_issued <= r_issued + 16'd1;
          if (w_load_beat) begin
            r_recvd <= r_recvd + 16'd1;
            if (r_recvd + 16'd1 == r_rows) r_state <= S_KICK;
          end
        end
        S_KICK: r_state <= S_COMPUTE;
        S_COMPUTE: begin
          if (sa_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // A short write count means rows went missing even without an overflow.
          if (w_empty && !w_push) begin
            if (r_wcnt != r_rows) r_err <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_res_valid    <= 1'b1;
          r_res_complete <= ~r_err;
          r_res_error    <= r_err;
          r_err          <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tca_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OFIFO_D)
  ) u_ofifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_din   (sa_dout),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready     = (r_state == S_IDLE);
  assign rd_valid      = w_rd_want;
  assign rd_addr       = w_rd_want ? r_base + ADDR_W'(r_issued) : '0;
  assign sa_valid      = w_load_beat | (r_state == S_KICK);
  assign sa_load_ifmap = w_load_beat;
  assign sa_start      = (r_state == S_KICK);
  assign sa_din        = w_load_beat ? rd_rdata : '0;
  assign wr_valid      = w_out_phase & ~w_empty;
  assign wr_addr       = wr_valid ? r_psum + ADDR_W'(r_wcnt) : '0;
  assign wr_data       = wr_valid ? w_head : '0;
  assign res_valid     = r_res_valid;
  assign res_complete  = r_res_complete;
  assign res_error     = r_res_error;

endmodule

// File: tb/tb_tca_sa_sequencer.sv
// Directed bench for tca_sa_sequencer with a latency-1 scratchpad and a small write-queue model.
module tb_tca_sa_sequencer;
  import tca_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [19:0] req_base_addr, req_psum_addr;
  logic [15:0] req_rows;
  logic        rd_valid, rd_ready, rd_rvalid;
  logic [19:0] rd_addr;
  tca_row_t    rd_rdata;
  logic        sa_valid, sa_load_ifmap, sa_start, sa_rvalid, sa_done;
  tca_row_t    sa_din, sa_dout;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_addr;
  tca_row_t    wr_data;
  logic        res_valid, res_complete, res_error;

  int          total = 0;
  int          bad   = 0;
  tca_row_t    q[$];
  int          wcnt;
  logic [19:0] psum_m;

  always #5 clk = ~clk;

  tca_sa_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr), .req_psum_addr(req_psum_addr), .req_rows(req_rows),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .sa_valid(sa_valid), .sa_load_ifmap(sa_load_ifmap), .sa_start(sa_start), .sa_din(sa_din),
    .sa_rvalid(sa_rvalid), .sa_done(sa_done), .sa_dout(sa_dout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_valid(res_valid), .res_complete(res_complete), .res_error(res_error)
  );

  function automatic tca_row_t rowdat(input logic [19:0] a);
    return {8'hA5, 100'h0, a};
  endfunction

  function automatic tca_row_t odat(input int t, input int k);
    return {32'(t), 64'h0123_4567_89AB_CDEF, 32'(k)};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0b want %0b", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic chka(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic chkd(input string tag, input tca_row_t obs, input tca_row_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [15:0] rows, input logic [19:0] base, input logic [19:0] psum);
    req_valid = 1'b1; req_rows = rows; req_base_addr = base; req_psum_addr = psum;
    psum_m = psum; q.delete(); wcnt = 0;
    #1;
    chk1("req_ready_idle", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input int rows, input logic [19:0] base, input bit toggle);
    int          issued = 0;
    int          got = 0;
    int          n = 0;
    bit          pend = 1'b0;
    bit          nxt;
    logic [19:0] paddr = '0;
    while (got < rows && n < 200) begin
      rd_ready  = toggle ? (n % 2 == 0) : 1'b1;
      rd_rvalid = pend;
      rd_rdata  = pend ? rowdat(paddr) : '0;
      #1;
      chk1("rd_valid", rd_valid, issued < rows);
      if (issued < rows) chka("rd_addr", rd_addr, base + 20'(issued));
      chk1("load_beat", sa_valid && sa_load_ifmap, pend);
      if (pend) begin
        chkd("sa_din", sa_din, rowdat(paddr));
        got++;
      end
      nxt = (issued < rows) && rd_ready;
      if (nxt) begin
        paddr = base + 20'(issued);
        issued++;
      end
      pend = nxt;
      cyc();
      n++;
    end
    rd_rvalid = 1'b0; rd_ready = 1'b0; rd_rdata = '0;
    #1;
    chk1("kick_start", sa_start, 1'b1);
    chk1("kick_valid", sa_valid, 1'b1);
    chk1("kick_ld", sa_load_ifmap, 1'b0);
    chk1("kick_rd", rd_valid, 1'b0);
    cyc();
    chk1("start_once", sa_start, 1'b0);
  endtask

  task automatic sa_step(input bit push, input tca_row_t dout, input bit done, input bit wrdy);
    sa_rvalid = push; sa_dout = dout; sa_done = done; wr_ready = wrdy;
    #1;
    chk1("wr_valid", wr_valid, q.size() > 0);
    if (q.size() > 0) begin
      chka("wr_addr", wr_addr, psum_m + 20'(wcnt));
      chkd("wr_data", wr_data, q[0]);
      if (wrdy) begin
        void'(q.pop_front());
        wcnt++;
      end
    end
    if (push && q.size() < 4) q.push_back(dout);
    cyc();
    sa_rvalid = 1'b0; sa_done = 1'b0; sa_dout = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      sa_step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
  endtask

  task automatic finish_resp(input bit exp_err);
    #1;
    chk1("drain_empty", wr_valid, 1'b0);
    chk1("res_early", res_valid, 1'b0);
    cyc();
    chk1("resp_busy", req_ready, 1'b0);
    chk1("res_early2", res_valid, 1'b0);
    cyc();
    chk1("res_valid", res_valid, 1'b1);
    chk1("res_complete", res_complete, !exp_err);
    chk1("res_error", res_error, exp_err);
    chk1("req_ready_back", req_ready, 1'b1);
    cyc();
    chk1("res_pulse", res_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_base_addr = '0; req_psum_addr = '0; req_rows = '0;
    rd_ready = 1'b0; rd_rvalid = 1'b0; rd_rdata = '0;
    sa_rvalid = 1'b0; sa_done = 1'b0; sa_dout = '0; wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_sa_valid", sa_valid, 1'b0);
    chk1("rst_sa_start", sa_start, 1'b0);
    chk1("rst_wr_valid", wr_valid, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_res_error", res_error, 1'b0);
    chka("rst_rd_addr", rd_addr, 20'h0);
    rst = 1'b0;
    cyc();

    // 1: basic 4-row tile
    start_req(16'd4, 20'h00100, 20'h00200);
    do_load(4, 20'h00100, 1'b0);
    for (int k = 0; k < 4; k++) sa_step(1'b1, odat(1, k), 1'b0, 1'b1);
    sa_step(1'b0, '0, 1'b1, 1'b1);
    drain();
    finish_resp(1'b0);

    // 2: rows=0 and rows=17 are rejected without any reads
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_rows = (i == 0) ? 16'd0 : 16'd17;
      #1;
      chk1("bad_req_ready", req_ready, 1'b1);
      cyc();
      req_valid = 1'b0;
      #1;
      chk1("bad_no_rd", rd_valid, 1'b0);
      chk1("bad_res_early", res_valid, 1'b0);
      cyc();
      chk1("bad_res_valid", res_valid, 1'b1);
      chk1("bad_res_error", res_error, 1'b1);
      chk1("bad_res_complete", res_complete, 1'b0);
      cyc();
    end

    // 3: 8 rows, stalling reads, FIFO held full while writes are blocked
    start_req(16'd8, 20'h01000, 20'h02000);
    do_load(8, 20'h01000, 1'b1);
    for (int k = 0; k < 4; k++) sa_step(1'b1, odat(3, k), 1'b0, 1'b0);
    repeat (6) sa_step(1'b0, '0, 1'b0, 1'b0);
    for (int k = 4; k < 8; k++) sa_step(1'b1, odat(3, k), 1'b0, 1'b1);
    sa_step(1'b0, '0, 1'b1, 1'b1);
    drain();
    finish_resp(1'b0);

    // 4: fifth row into a full FIFO with no pop is dropped
    start_req(16'd4, 20'h04000, 20'h05000);
    do_load(4, 20'h04000, 1'b0);
    for (int k = 0; k < 5; k++) sa_step(1'b1, odat(4, k), 1'b0, 1'b0);
    sa_step(1'b0, '0, 1'b1, 1'b0);
    drain();
    finish_resp(1'b1);

    // 5: last row and done together, addresses wrapping past the top
    start_req(16'd2, 20'hFFFFF, 20'hFFFFF);
    do_load(2, 20'hFFFFF, 1'b0);
    sa_step(1'b1, odat(5, 0), 1'b0, 1'b1);
    sa_step(1'b1, odat(5, 1), 1'b1, 1'b1);
    drain();
    finish_resp(1'b0);

    // 6: reset mid-COMPUTE, then a normal tile
    start_req(16'd4, 20'h00300, 20'h00400);
    do_load(4, 20'h00300, 1'b0);
    sa_step(1'b1, odat(6, 0), 1'b0, 1'b0);
    sa_rvalid = 1'b1; sa_dout = odat(6, 1); rst = 1'b1;
    #1;
    chk1("arst_wr_valid", wr_valid, 1'b0);
    chk1("arst_req_ready", req_ready, 1'b1);
    chk1("arst_sa_valid", sa_valid, 1'b0);
    chk1("arst_rd_valid", rd_valid, 1'b0);
    chk1("arst_res_valid", res_valid, 1'b0);
    chkd("arst_wr_data", wr_data, '0);
    cyc();
    cyc();
    rst = 1'b0; sa_rvalid = 1'b0; sa_dout = '0;
    cyc();
    chk1("post_rst_res", res_valid, 1'b0);
    chk1("post_rst_ready", req_ready, 1'b1);
    chk1("post_rst_wr", wr_valid, 1'b0);
    start_req(16'd2, 20'h00600, 20'h00700);
    do_load(2, 20'h00600, 1'b0);
    sa_step(1'b1, odat(7, 0), 1'b0, 1'b1);
    sa_step(1'b1, odat(7, 1), 1'b0, 1'b1);
    sa_step(1'b0, '0, 1'b1, 1'b1);
    drain();
    finish_resp(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
